// File: rtl/i2c_write_master.sv
`timescale 1ns/1ps
// Bit-level I2C write engine: START, three bytes with ACK slots, STOP, then a done/ack report.
// Optional macro I2C_NACK_ABORT_EN: a NACK ends the frame with STOP after that ACK slot.
module i2c_write_master #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] i2c_data,
  output logic        done,
  output logic        ack,
  output logic        busy,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   shift_q, shift_d;
  logic          nack_q, nack_d;
  logic          scl_q, scl_d;
  logic          sda_low_q, sda_low_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [1:0]    sync_q, sync_d;
  logic          tick;

  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;
  assign i2c_sclk = scl_q;
  assign done     = done_q;
  assign ack      = ack_q;
  assign busy     = busy_q;

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    nack_d    = nack_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sync_d    = {sync_q[0], i2c_sdat};
    tick      = (qcnt_q == QMAX);
    scl_d     = 1'b1;
    sda_low_d = 1'b0;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      qcnt_d = tick ? '0 : qcnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        qcnt_d = '0;
        if (start) begin
          shift_d = i2c_data;
          ack_d   = 1'b0;
          busy_d  = 1'b1;
          nack_d  = 1'b0;
          phase_d = '0;
          bit_d   = '0;
          byte_d  = '0;
          state_d = S_START;
        end
      end
      S_START: if (tick) begin
        phase_d = phase_q + 1'b1;
        if (phase_q == 2'd1) begin
          phase_d = '0;
          bit_d   = '0;
          state_d = S_BIT;
        end
      end
      S_BIT: if (tick) begin
        phase_d = phase_q + 1'b1;
        if (phase_q == 2'd3) begin
          shift_d = {shift_q[22:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: if (tick) begin
        phase_d = phase_q + 1'b1;
        // Last cycle of q2: the synchronized line is the slave's answer.
        if (phase_q == 2'd2 && sync_q[1]) nack_d = 1'b1;
        if (phase_q == 2'd3) begin
          byte_d  = byte_q + 1'b1;
          bit_d   = '0;
          state_d = S_BIT;
`ifdef I2C_NACK_ABORT_EN
          if (byte_q == 2'd2 || nack_q) begin
            phase_d = '0;
            state_d = S_STOP;
          end
`else
          if (byte_q == 2'd2) begin
            phase_d = '0;
            state_d = S_STOP;
          end
`endif
        end
      end
      S_STOP: if (tick) begin
        phase_d = phase_q + 1'b1;
        if (phase_q == 2'd2) begin
          phase_d = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ack_d   = !nack_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Line levels are registered for the state/quarter being entered.
    case (state_d)
      S_START: begin
        scl_d     = (phase_d == 2'd0);
        sda_low_d = 1'b1;
      end
      S_BIT: begin
        scl_d     = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_low_d = !shift_d[23];
      end
      S_ACK: scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
      S_STOP: begin
        scl_d     = (phase_d != 2'd0);
        sda_low_d = (phase_d != 2'd2);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      sync_q    <= 2'b11;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      nack_q    <= nack_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      sync_q    <= sync_d;
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
`timescale 1ns/1ps
// Directed bench for i2c_write_master: a bus monitor/slave decodes SCL/SDA into events
// that are checked against a queue of expected events pushed when each frame is launched.
module tb_i2c_write_master;
  localparam int CLK_DIV = 4;
  localparam int EV_A = 256, EV_N = 257, EV_START = 512, EV_STOP = 513;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] i2c_data = '0;
  wire         done, ack, busy, i2c_sclk;
  wire         i2c_sdat;
  logic        slave_low = 1'b0;

  pullup (i2c_sdat);
  assign i2c_sdat = slave_low ? 1'b0 : 1'bz;

  i2c_write_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .i2c_data(i2c_data),
    .done(done), .ack(ack), .busy(busy), .i2c_sclk(i2c_sclk), .i2c_sdat(i2c_sdat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0, done_cnt = 0;
  int exp_q[$];
  logic [2:0] nack_mask = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic see_event(input int ev);
    if (exp_q.size() == 0) chk("unexpected_bus_event", ev, -1);
    else chk("bus_event", ev, exp_q.pop_front());
  endtask

  // Bus monitor and ACKing slave, sampled mid-cycle away from the DUT's edges.
  logic scl_p = 1'b1, sda_p = 1'b1;
  int   bitn = 0, byten = 0;
  logic [7:0] rx = '0;
  always @(negedge clk) begin
    logic scl, sda;
    scl = i2c_sclk;
    sda = (i2c_sdat === 1'b0) ? 1'b0 : 1'b1;
    if (reset) begin
      bitn = 0; byten = 0; slave_low = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (sda != sda_p) begin
        if (scl_p && scl) begin
          if (!sda) begin bitn = 0; byten = 0; end
          see_event(sda ? EV_STOP : EV_START);
        end else begin
          chk("sda_change_with_scl_low", {30'd0, scl_p, scl}, 0);
        end
      end
      if (!scl_p && scl) begin
        if (bitn < 8) begin
          rx = {rx[6:0], sda};
          bitn++;
        end else if (bitn == 8) begin
          see_event({24'd0, rx});
          see_event(sda ? EV_N : EV_A);
          bitn = 9;
        end
      end
      if (scl_p && !scl) begin
        if (bitn == 8) slave_low = (byten < 3) ? !nack_mask[byten] : 1'b0;
        else if (bitn == 9) begin slave_low = 1'b0; bitn = 0; byten++; end
      end
    end
    scl_p = scl;
    sda_p = (i2c_sdat === 1'b0) ? 1'b0 : 1'b1;
  end

  task automatic push_frame(input logic [23:0] d, input logic [2:0] nm,
                            output int quarters, output logic exp_ack);
    exp_q.push_back(EV_START);
    quarters = 5;
    exp_ack  = 1'b1;
    for (int b = 0; b < 3; b++) begin
      logic [7:0] byt;
      byt = d[23 - 8*b -: 8];
      exp_q.push_back({24'd0, byt});
      exp_q.push_back(nm[b] ? EV_N : EV_A);
      quarters += 36;
      if (nm[b]) exp_ack = 1'b0;
`ifdef I2C_NACK_ABORT_EN
      if (nm[b]) break;
`endif
    end
    exp_q.push_back(EV_STOP);
  endtask

  task automatic run_frame(input string tag, input logic [23:0] d, input logic [2:0] nm,
                           input bit extra);
    int q, a, at, d0;
    logic ea;
    push_frame(d, nm, q, ea);
    nack_mask = nm;
    i2c_data  = d;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = cyc;
    i2c_data = ~d;
    chk({tag, " busy_at_accept"}, busy, 1);
    chk({tag, " ack_cleared"}, ack, 0);
    at = -1;
    for (int k = 1; k <= q*CLK_DIV + 20 && at < 0; k++) begin
      @(posedge clk); #1;
      start = extra && (k == 10 || k == 50 || k == 200);
      if (done) at = cyc;
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, at - a, q*CLK_DIV);
    chk({tag, " ack"}, ack, ea);
    chk({tag, " busy_at_done"}, busy, 0);
    repeat (20) @(posedge clk);
    #1;
    chk({tag, " done_pulses"}, done_cnt - d0, 1);
    chk({tag, " events_left"}, exp_q.size(), 0);
    $display("frame %s data=%06h nack=%b quarters=%0d done_after=%0d ack=%b", tag, d, nm, q, at - a, ack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, a, at1, at2, d0;
    logic ea;

    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("reset_scl", i2c_sclk, 1);
    chk("reset_sda", (i2c_sdat === 1'b0) ? 0 : 1, 1);
    chk("reset_done", done, 0);
    chk("reset_ack", ack, 0);
    chk("reset_busy_start_ignored", busy, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("reset checked");

    run_frame("ack_all", 24'h340C02, 3'b000, 1'b0);
    run_frame("nack_byte1", 24'h340C02, 3'b010, 1'b0);
    run_frame("ignored_starts", 24'h340C02, 3'b000, 1'b1);

    // Reset during the 2nd bit of byte 1 (quarters 42..45 of the frame).
    exp_q.push_back(EV_START);
    exp_q.push_back(32'h34);
    exp_q.push_back(EV_A);
    nack_mask = '0;
    i2c_data = 24'h340C02;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = cyc;
    repeat (170) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_scl", i2c_sclk, 1);
    chk("abort_sda", (i2c_sdat === 1'b0) ? 0 : 1, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_events_left", exp_q.size(), 0);
    $display("reset mid-frame at +%0d cycles, done pulses=%0d", cyc - a, done_cnt - d0);

    run_frame("after_reset", 24'h340C02, 3'b000, 1'b0);

    // start held high: two frames back to back.
    nack_mask = '0;
    push_frame(24'h341201, 3'b000, q, ea);
    push_frame(24'h341201, 3'b000, q, ea);
    i2c_data = 24'h341201;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    at1 = -1;
    for (int k = 0; k < 600 && at1 < 0; k++) begin
      @(posedge clk); #1;
      if (done) at1 = cyc;
    end
    chk("b2b_first_done", at1 - a, 113*CLK_DIV);
    chk("b2b_first_ack", ack, 1);
    @(posedge clk); #1;
    chk("b2b_idle_gap_busy", busy, 0);
    @(posedge clk); #1;
    chk("b2b_second_accept_busy", busy, 1);
    chk("b2b_second_accept_ack_cleared", ack, 0);
    chk("b2b_second_start_sda", (i2c_sdat === 1'b0) ? 0 : 1, 0);
    at2 = -1;
    for (int k = 0; k < 600 && at2 < 0; k++) begin
      @(posedge clk); #1;
      if (done) at2 = cyc;
    end
    start = 1'b0;
    chk("b2b_second_done", at2 - a, 2*113*CLK_DIV + 2);
    chk("b2b_second_ack", ack, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("b2b_done_pulses", done_cnt - d0, 2);
    chk("b2b_events_left", exp_q.size(), 0);
    $display("back-to-back frames: done at +%0d and +%0d", at1 - a, at2 - a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
